// File: rtl/tile_map_ctrl.sv
// Tile map store for the pixel generator: 1-cycle word read port, buffered
// single-tile writes committed in IDLE (optionally only in blanking), full-map clear.
//
// state | meaning
// IDLE  | reads plus FIFO commits; clr_req starts a clear
// CLEAR | one map word per cycle set to CLEAR_VAL, no commits, no accepts
module tile_map_ctrl #(
  parameter int         N_WORDS    = 510,
  parameter int         WORD_AW    = 9,
  parameter int         TILE_AW    = 11,
  parameter int         FIFO_DEPTH = 4,
  parameter int         SAFE_WRITE = 1,
  parameter logic [7:0] CLEAR_VAL  = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_AW-1:0] current_tile,
  input  logic               vde,
  output logic [31:0]        sprite_addr,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [TILE_AW-1:0] wr_tile,
  input  logic [7:0]         wr_sprite,
  input  logic               clr_req,
  output logic               clr_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_nxt;
  logic [WORD_AW-1:0] cnt, cnt_nxt;
  logic               clear_we;

  logic [31:0]        map [N_WORDS];

  logic [TILE_AW+7:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        fifo_cnt;
  logic               push, pop;

  logic [TILE_AW-1:0] pop_tile;
  logic [7:0]         pop_sprite;
  logic [WORD_AW-1:0] pop_word;
  logic [1:0]         pop_lane;
  logic               pop_hit;

  assign wr_ready   = (fifo_cnt != (PW+1)'(FIFO_DEPTH)) && (state == IDLE);
  assign push       = wr_valid && wr_ready;
  assign clr_busy   = (state == CLEAR);

  assign {pop_tile, pop_sprite} = fifo_mem[rd_ptr];
  assign pop_word   = WORD_AW'(pop_tile >> 2);
  assign pop_lane   = pop_tile[1:0];
  assign pop_hit    = 32'(pop_tile) < 32'(4 * N_WORDS);

  // Commits are held off in the clr_req cycle so pending writes land after the clear.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clear_we  = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        pop = (fifo_cnt != '0) && (SAFE_WRITE == 0 || !vde) && !clr_req;
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        clear_we = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == WORD_AW'(N_WORDS - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Map contents are not reset; the post-reset clear initialises them.
  always_ff @(posedge clk) begin
    if (clear_we)
      map[cnt] <= {4{CLEAR_VAL}};
    else if (pop && pop_hit)
      map[pop_word][8*pop_lane +: 8] <= pop_sprite;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sprite_addr <= '0;
    else if (32'(current_tile) < 32'(N_WORDS))
      sprite_addr <= map[current_tile];
    else
      sprite_addr <= '0;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {wr_tile, wr_sprite};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
